// File: rtl/miller_frame_encoder.sv
// ISO14443A 106 kb/s Modified Miller transmitter: serialises frame bytes LSB first
// into a registered carrier-pause envelope framed as SoF (Z), data, EoF (0 then Y).
module miller_frame_encoder #(
    parameter int ETU_CLKS   = 32,
    parameter int PAUSE_CLKS = 7,
    parameter int CNT_W      = 5
) (
    input  logic       in_clk,
    input  logic       in_PoR,
    input  logic [7:0] in_data,
    input  logic [3:0] in_nbits,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       out_ready,
    output logic       out_pause,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_err
);
    typedef enum logic [2:0] {S_IDLE, S_SOF, S_DATA, S_EOF0, S_EOF_Y, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ETU_CLKS - 1);
    localparam logic [CNT_W-1:0] X_START  = CNT_W'(ETU_CLKS / 2);
    localparam logic [CNT_W-1:0] X_END    = CNT_W'(ETU_CLKS / 2 + PAUSE_CLKS);
    localparam logic [CNT_W-1:0] Z_END    = CNT_W'(PAUSE_CLKS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d, hold_data_q, hold_data_d;
    logic [3:0]       bits_q, bits_d, hold_nbits_q, hold_nbits_d;
    logic             last_q, last_d, hold_last_q, hold_last_d;
    logic             hold_full_q, hold_full_d, prev_x_q, prev_x_d;
    logic             drop_q, drop_d, pause_q, pause_d;
    logic             done_q, done_d, err_q, err_d;

    logic acc, etu_end, byte_end, load, underrun, in_z, in_x;

    assign acc      = in_valid && !hold_full_q;
    assign etu_end  = (cnt_q == CNT_LAST);
    assign byte_end = (bits_q == 4'd1);
    // Next byte goes straight into the shifter so the wire sees no gap between bytes.
    assign load     = etu_end && ((state_q == S_SOF) ||
                      (state_q == S_DATA && byte_end && !last_q && hold_full_q));
    assign underrun = etu_end && state_q == S_DATA && byte_end && !last_q && !hold_full_q;
    assign in_z     = (cnt_q < Z_END);
    assign in_x     = (cnt_q >= X_START) && (cnt_q < X_END);

    always_ff @(posedge in_clk) begin
        if (in_PoR) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            bits_q       <= '0;
            last_q       <= 1'b0;
            prev_x_q     <= 1'b0;
            hold_data_q  <= '0;
            hold_nbits_q <= '0;
            hold_last_q  <= 1'b0;
            hold_full_q  <= 1'b0;
            drop_q       <= 1'b0;
            pause_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            bits_q       <= bits_d;
            last_q       <= last_d;
            prev_x_q     <= prev_x_d;
            hold_data_q  <= hold_data_d;
            hold_nbits_q <= hold_nbits_d;
            hold_last_q  <= hold_last_d;
            hold_full_q  <= hold_full_d;
            drop_q       <= drop_d;
            pause_q      <= pause_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (hold_full_q || acc) state_d = S_SOF;
            S_SOF:   if (etu_end) state_d = S_DATA;
            S_DATA:  if (etu_end && byte_end && (last_q || !hold_full_q)) state_d = S_EOF0;
            S_EOF0:  if (etu_end) state_d = S_EOF_Y;
            S_EOF_Y: if (etu_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = (state_q == S_IDLE || state_q == S_DONE || etu_end) ? '0 : cnt_q + 1'b1;
        shift_d      = shift_q;
        bits_d       = bits_q;
        last_d       = last_q;
        prev_x_d     = prev_x_q;
        hold_data_d  = hold_data_q;
        hold_nbits_d = hold_nbits_q;
        hold_last_d  = hold_last_q;
        hold_full_d  = hold_full_q;
        drop_d       = drop_q;
        if (state_q == S_SOF) prev_x_d = 1'b0;
        if (state_q == S_DATA && etu_end) begin
            prev_x_d = shift_q[0];
            shift_d  = shift_q >> 1;
            bits_d   = bits_q - 4'd1;
        end
        if (load) begin
            shift_d     = hold_data_q;
            bits_d      = hold_nbits_q;
            last_d      = hold_last_q;
            hold_full_d = 1'b0;
        end
        if (underrun) drop_d = 1'b1;
        // Anything that arrived after an underrun belongs to the aborted frame.
        if (state_q == S_DONE) begin
            drop_d = 1'b0;
            if (drop_q) hold_full_d = 1'b0;
        end
        if (acc) begin
            hold_full_d  = 1'b1;
            hold_data_d  = in_data;
            hold_nbits_d = (in_nbits == 4'd0 || in_nbits > 4'd8) ? 4'd8 : in_nbits;
            hold_last_d  = in_last;
        end
    end

    always_comb begin
        unique case (state_q)
            S_SOF:   pause_d = in_z;
            S_DATA:  pause_d = shift_q[0] ? in_x : (!prev_x_q && in_z);
            S_EOF0:  pause_d = !prev_x_q && in_z;
            default: pause_d = 1'b0;
        endcase
        done_d    = (state_q == S_EOF_Y) && etu_end;
        err_d     = underrun;
        out_ready = !hold_full_q;
        out_busy  = (state_q == S_SOF) || (state_q == S_DATA) ||
                    (state_q == S_EOF0) || (state_q == S_EOF_Y);
        out_pause = pause_q;
        out_done  = done_q;
        out_err   = err_q;
    end
endmodule

// File: tb/tb_miller_frame_encoder.sv
// Randomised and directed bench for miller_frame_encoder against a symbol-level model.
module tb_miller_frame_encoder;
    localparam int ETU = 32;
    localparam int PC  = 7;
    localparam int SY = 0, SX = 1, SZ = 2;

    logic       clk = 1'b0;
    logic       por;
    logic [7:0] data;
    logic [3:0] nbits;
    logic       last, valid;
    logic       ready, pause, busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    miller_frame_encoder #(.ETU_CLKS(32), .PAUSE_CLKS(7), .CNT_W(5)) dut (
        .in_clk(clk), .in_PoR(por), .in_data(data), .in_nbits(nbits), .in_last(last),
        .in_valid(valid), .out_ready(ready), .out_pause(pause), .out_busy(busy),
        .out_done(done), .out_err(err)
    );

    // frame to send
    logic [7:0] fb_data[$];
    logic [3:0] fb_nbits[$];
    logic       fb_last[$];
    // model
    int sym[$];
    bit exp_pause[$];
    int exp_total, exp_err_idx, exp_pulses;
    // capture, indexed from the first busy cycle
    bit cap_pause[$], cap_ready[$];
    int busy_len, done_idx, done_cnt, err_idx, err_cnt, pause_bad, pulses;

    task automatic clear_frame();
        fb_data.delete(); fb_nbits.delete(); fb_last.delete();
    endtask

    task automatic add_byte(input logic [7:0] d, input logic [3:0] n, input logic l);
        fb_data.push_back(d); fb_nbits.push_back(n); fb_last.push_back(l);
    endtask

    // Expected symbol stream and pause envelope straight from the Miller rules.
    task automatic build_model();
        bit px, p;
        int n, j, c;
        logic [7:0] d;
        sym.delete(); exp_pause.delete();
        exp_err_idx = -1;
        sym.push_back(SZ); px = 0;
        for (int b = 0; b < fb_data.size(); b++) begin
            d = fb_data[b];
            n = (fb_nbits[b] == 0 || fb_nbits[b] > 8) ? 8 : int'(fb_nbits[b]);
            for (int k = 0; k < n; k++) begin
                if (d[k]) begin sym.push_back(SX); px = 1; end
                else begin sym.push_back(px ? SY : SZ); px = 0; end
            end
            if (fb_last[b]) break;
            if (b == fb_data.size() - 1) exp_err_idx = sym.size() * ETU;
        end
        sym.push_back(px ? SY : SZ);
        sym.push_back(SY);
        exp_total = sym.size() * ETU;
        exp_pulses = 0;
        foreach (sym[k]) if (sym[k] != SY) exp_pulses++;
        for (int i = 0; i < exp_total + 4; i++) begin
            j = i - 1; p = 0;
            if (j >= 0 && j < exp_total) begin
                c = j % ETU;
                if (sym[j / ETU] == SX) p = (c >= ETU / 2) && (c < ETU / 2 + PC);
                else if (sym[j / ETU] == SZ) p = (c < PC);
            end
            exp_pause.push_back(p);
        end
    endtask

    // Offers the frame bytes with random gaps and records outputs from the first busy cycle.
    task automatic run_frame(input int max_gap);
        int idx = 0, i = -1, wt = 0, gap;
        cap_pause.delete(); cap_ready.delete();
        busy_len = 0; done_idx = -1; done_cnt = 0; err_idx = -1; err_cnt = 0;
        gap = $urandom_range(0, max_gap);
        while (i < exp_total + 3) begin
            @(negedge clk);
            if (i >= 0 || busy) begin
                i++;
                cap_pause.push_back(pause); cap_ready.push_back(ready);
                if (busy) busy_len++;
                if (done) begin done_cnt++; if (done_idx < 0) done_idx = i; end
                if (err) begin err_cnt++; if (err_idx < 0) err_idx = i; end
            end else if (++wt > 100) begin
                n_tests++; n_fail++;
                $display("FAIL frame_start: busy not seen in 100 cycles, required within 100");
                break;
            end
            if (idx < fb_data.size() && gap == 0) begin
                valid = 1'b1; data = fb_data[idx]; nbits = fb_nbits[idx]; last = fb_last[idx];
                if (ready) begin idx++; gap = $urandom_range(0, max_gap); end
            end else begin
                valid = 1'b0; data = 8'($urandom); nbits = 4'($urandom); last = 1'($urandom);
                if (gap > 0) gap--;
            end
        end
        valid = 1'b0;
        pause_bad = 0; pulses = 0;
        foreach (exp_pause[k]) if (k >= cap_pause.size() || cap_pause[k] != exp_pause[k]) pause_bad++;
        foreach (cap_pause[k]) if (cap_pause[k] && (k == 0 || !cap_pause[k-1])) pulses++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        por = 1'b1; valid = 1'b0; data = 8'h00; nbits = 4'd0; last = 1'b0;
        repeat (3) @(negedge clk);
        por = 1'b0;
        n_tests++; if (pause !== 1'b0) begin n_fail++; $display("FAIL reset_pause: got %b want 0", pause); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_tests++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b want 00", {done, err}); end
    endtask

    task automatic test_reqa();
        clear_frame(); add_byte(8'h26, 4'd7, 1'b1); build_model(); run_frame(0);
        n_tests++; if (pause_bad != 0) begin n_fail++; $display("FAIL reqa_envelope: %0d cycles differ, want 0", pause_bad); end
        n_tests++; if (busy_len != 320) begin n_fail++; $display("FAIL reqa_busy: got %0d want 320", busy_len); end
        n_tests++; if (pulses != 7) begin n_fail++; $display("FAIL reqa_pulses: got %0d want 7", pulses); end
        n_tests++; if (done_idx != 320 || done_cnt != 1) begin n_fail++; $display("FAIL reqa_done: at %0d x%0d want 320 x1", done_idx, done_cnt); end
        n_tests++; if (err_cnt != 0) begin n_fail++; $display("FAIL reqa_err: got %0d pulses want 0", err_cnt); end
    endtask

    task automatic test_back_to_back();
        int s = 0;
        clear_frame(); add_byte(8'h93, 4'd8, 1'b0); add_byte(8'h20, 4'd8, 1'b1);
        build_model(); run_frame(0);
        for (int k = 9 * ETU + 1; k <= 10 * ETU; k++) s += int'(cap_pause[k]);
        n_tests++; if (pause_bad != 0) begin n_fail++; $display("FAIL b2b_envelope: %0d cycles differ, want 0", pause_bad); end
        n_tests++; if (busy_len != 19 * ETU) begin n_fail++; $display("FAIL b2b_busy: got %0d want %0d", busy_len, 19 * ETU); end
        n_tests++; if (cap_ready[5] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b want 0", cap_ready[5]); end
        n_tests++; if (s != 0) begin n_fail++; $display("FAIL b2b_boundary_y: %0d pause cycles want 0", s); end
        n_tests++; if (done_idx != 19 * ETU) begin n_fail++; $display("FAIL b2b_done: got %0d want %0d", done_idx, 19 * ETU); end
    endtask

    task automatic test_underrun();
        clear_frame(); add_byte(8'hFF, 4'd8, 1'b0); build_model(); run_frame(0);
        n_tests++; if (err_idx != 9 * ETU || err_cnt != 1) begin n_fail++; $display("FAIL underrun_err: at %0d x%0d want %0d x1", err_idx, err_cnt, 9 * ETU); end
        n_tests++; if (pulses != 9) begin n_fail++; $display("FAIL underrun_pulses: got %0d want 9", pulses); end
        n_tests++; if (done_idx != 11 * ETU) begin n_fail++; $display("FAIL underrun_done: got %0d want %0d", done_idx, 11 * ETU); end
        n_tests++; if (pause_bad != 0) begin n_fail++; $display("FAIL underrun_envelope: %0d cycles differ, want 0", pause_bad); end
    endtask

    task automatic test_all_zero();
        clear_frame(); add_byte(8'h00, 4'd8, 1'b1); build_model(); run_frame(1);
        n_tests++; if (pulses != 10) begin n_fail++; $display("FAIL zero_pulses: got %0d want 10", pulses); end
        n_tests++; if (pause_bad != 0) begin n_fail++; $display("FAIL zero_envelope: %0d cycles differ, want 0", pause_bad); end
        n_tests++; if (busy_len != 11 * ETU) begin n_fail++; $display("FAIL zero_busy: got %0d want %0d", busy_len, 11 * ETU); end
    endtask

    task automatic test_nbits0();
        clear_frame(); add_byte(8'hA5, 4'd0, 1'b1); build_model(); run_frame(1);
        n_tests++; if (busy_len != 11 * ETU) begin n_fail++; $display("FAIL nbits0_busy: got %0d want %0d", busy_len, 11 * ETU); end
        n_tests++; if (pause_bad != 0) begin n_fail++; $display("FAIL nbits0_envelope: %0d cycles differ, want 0", pause_bad); end
        n_tests++; if (pulses != 6) begin n_fail++; $display("FAIL nbits0_pulses: got %0d want 6", pulses); end
    endtask

    task automatic test_mid_reset();
        int w = 0;
        bit p_before;
        @(negedge clk); valid = 1'b1; data = 8'h26; nbits = 4'd7; last = 1'b1;
        @(negedge clk); valid = 1'b0;
        while (!busy && w < 50) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        p_before = pause;
        por = 1'b1;
        @(negedge clk);
        por = 1'b0;
        n_tests++; if (p_before !== 1'b1) begin n_fail++; $display("FAIL midrst_pause_before: got %b want 1", p_before); end
        n_tests++; if (pause !== 1'b0) begin n_fail++; $display("FAIL midrst_pause: got %b want 0", pause); end
        n_tests++; if (busy !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_ready: got %b%b want 01", busy, ready); end
        clear_frame(); add_byte(8'h26, 4'd7, 1'b1); build_model(); run_frame(0);
        n_tests++; if (pause_bad != 0 || busy_len != 320) begin n_fail++; $display("FAIL midrst_clean_frame: %0d bad, busy %0d want 0, 320", pause_bad, busy_len); end
    endtask

    task automatic test_random();
        int nb;
        for (int f = 0; f < 15; f++) begin
            clear_frame();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++)
                add_byte(8'($urandom), 4'($urandom_range(0, 15)),
                         (b == nb - 1) ? ($urandom_range(0, 4) != 0) : 1'b0);
            build_model(); run_frame(3);
            n_tests++; if (pause_bad != 0) begin n_fail++; $display("FAIL rand%0d_envelope: %0d cycles differ, want 0", f, pause_bad); end
            n_tests++; if (busy_len != exp_total) begin n_fail++; $display("FAIL rand%0d_busy: got %0d want %0d", f, busy_len, exp_total); end
            n_tests++; if (done_idx != exp_total || done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done: at %0d x%0d want %0d x1", f, done_idx, done_cnt, exp_total); end
            n_tests++; if (err_idx != exp_err_idx) begin n_fail++; $display("FAIL rand%0d_err: at %0d want %0d", f, err_idx, exp_err_idx); end
            n_tests++; if (pulses != exp_pulses) begin n_fail++; $display("FAIL rand%0d_pulses: got %0d want %0d", f, pulses, exp_pulses); end
        end
    endtask

    initial begin
        test_reset();
        test_reqa();
        test_back_to_back();
        test_underrun();
        test_all_zero();
        test_nbits0();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
